// File: rtl/cpu_regfile_xfer.sv
// cpu_regfile_xfer: CHIP-8 style V-register file plus a range block-transfer sequencer to/from RAM.
// Latency: reads combinational; store 1 cycle/element; load RD_WAIT+2 first, RD_WAIT+1 later; +1 DONE cycle.
// Backpressure: none; the CPU holds off while xfer_busy. Optional flag bank: define CPU_REGFILE_RPL_EN.
module cpu_regfile_xfer #(
    parameter int NREGS   = 16,
    parameter int W       = 8,
    parameter int AW      = 12,
    parameter int RD_WAIT = 1,
    parameter int NFLAGS  = 8,
    localparam int IW     = $clog2(NREGS)
) (
    input  logic          clk,
    input  logic          res_n,
    input  logic [IW-1:0] rd_a_sel,
    output logic [W-1:0]  rd_a_data,
    input  logic [IW-1:0] rd_b_sel,
    output logic [W-1:0]  rd_b_data,
    input  logic          wr_a_en,
    input  logic [IW-1:0] wr_a_sel,
    input  logic [W-1:0]  wr_a_data,
    input  logic          wr_f_en,
    input  logic [W-1:0]  wr_f_data,
    input  logic          xfer_start,
    input  logic          xfer_dir,
    input  logic          xfer_rpl,
    input  logic [IW-1:0] xfer_first,
    input  logic [IW-1:0] xfer_last,
    input  logic [AW-1:0] xfer_base,
    output logic          xfer_busy,
    output logic          xfer_done,
    output logic [AW-1:0] xfer_next_addr,
    output logic          ram_en,
    output logic          ram_wr,
    output logic [AW-1:0] ram_addr,
    output logic [W-1:0]  ram_in,
    input  logic [W-1:0]  ram_out
);
    localparam logic [IW-1:0] FLAG_IDX = IW'(NREGS - 1);
    localparam int WCW = (RD_WAIT > 1) ? $clog2(RD_WAIT) : 1;

    typedef enum logic [2:0] {IDLE, STORE, LADDR, LWAIT, LCAP, DONE} state_t;
    state_t state, state_d;

    logic [W-1:0]   regs [NREGS];
    logic [IW-1:0]  cur;
    logic [IW-1:0]  last_q;
    logic [AW-1:0]  cur_addr;
    logic           dir_up;
    logic [WCW-1:0] wait_cnt;
    logic           last_elem;
    logic           wait_end;
    logic           busy;
    logic           start_rpl;
    logic           rpl_act;

    assign busy      = (state != IDLE) && (state != DONE);
    assign xfer_busy = busy;
    assign last_elem = (cur == last_q);
    assign wait_end  = (wait_cnt == WCW'(RD_WAIT - 1));
    assign rd_a_data = regs[rd_a_sel];
    assign rd_b_data = regs[rd_b_sel];

`ifdef CPU_REGFILE_RPL_EN
    localparam int FW = (NFLAGS > 1) ? $clog2(NFLAGS) : 1;

    logic [W-1:0]  bank [NFLAGS];
    logic          rpl_q;
    logic          rpl_load_q;
    logic [IW-1:0] k;
    logic [FW-1:0] bidx;
    logic          bank_hit;

    assign start_rpl = xfer_rpl;
    assign rpl_act   = rpl_q;
    assign bidx      = FW'(k);
    // Registers beyond the bank depth still consume their slot but touch nothing.
    assign bank_hit  = (int'(cur) < NFLAGS) && (int'(k) < NFLAGS);

    // Latch flag-bank mode and track the element index used as bank address
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            rpl_q      <= 1'b0;
            rpl_load_q <= 1'b0;
            k          <= '0;
        end else if (state == IDLE && xfer_start) begin
            rpl_q      <= xfer_rpl;
            rpl_load_q <= xfer_dir;
            k          <= '0;
        end else if ((state == STORE || state == LCAP) && !last_elem) begin
            k          <= k + 1'b1;
        end
    end

    // Flag bank receives register values on an rpl store
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            for (int i = 0; i < NFLAGS; i++) bank[i] <= '0;
        end else if (state == STORE && rpl_q && !rpl_load_q && bank_hit) begin
            bank[bidx] <= regs[cur];
        end
    end
`else
    localparam int unused_nflags = NFLAGS;
    logic unused_rpl;
    assign unused_rpl = xfer_rpl;
    assign start_rpl  = 1'b0;
    assign rpl_act    = 1'b0;
`endif

    // Register array: CPU writes when idle, sequencer writes during loads
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else if (!busy) begin
            if (wr_a_en) regs[wr_a_sel] <= wr_a_data;
            // Flag write comes last so it wins over port A on VF.
            if (wr_f_en) regs[FLAG_IDX] <= wr_f_data;
        end else if (state == LCAP) begin
            regs[cur] <= ram_out;
        end
`ifdef CPU_REGFILE_RPL_EN
        else if (state == STORE && rpl_q && rpl_load_q && bank_hit) begin
            regs[cur] <= bank[bidx];
        end
`endif
    end

    // FSM state register
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) state <= IDLE;
        else        state <= state_d;
    end

    // Sequencer datapath: range latch, register/address stepping, wait count, next_addr
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            cur            <= '0;
            last_q         <= '0;
            cur_addr       <= '0;
            dir_up         <= 1'b1;
            wait_cnt       <= '0;
            xfer_next_addr <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (xfer_start) begin
                        cur      <= xfer_first;
                        last_q   <= xfer_last;
                        dir_up   <= (xfer_first <= xfer_last);
                        cur_addr <= xfer_base;
                        wait_cnt <= '0;
                    end
                end
                STORE, LCAP: begin
                    wait_cnt <= '0;
                    if (last_elem) begin
                        // cur_addr holds base+count-1 here; the flag bank leaves base untouched.
                        xfer_next_addr <= rpl_act ? cur_addr : cur_addr + 1'b1;
                    end else begin
                        cur <= dir_up ? cur + 1'b1 : cur - 1'b1;
                        if (!rpl_act) cur_addr <= cur_addr + 1'b1;
                    end
                end
                LWAIT: wait_cnt <= wait_cnt + 1'b1;
                default: ;
            endcase
        end
    end

    // Next-state and RAM/handshake outputs
    always_comb begin
        state_d   = state;
        ram_en    = 1'b0;
        ram_wr    = 1'b0;
        ram_addr  = '0;
        ram_in    = '0;
        xfer_done = 1'b0;
        case (state)
            IDLE: begin
                if (xfer_start) state_d = (xfer_dir && !start_rpl) ? LADDR : STORE;
            end
            STORE: begin
                if (!rpl_act) begin
                    ram_en   = 1'b1;
                    ram_wr   = 1'b1;
                    ram_addr = cur_addr;
                    ram_in   = regs[cur];
                end
                if (last_elem) state_d = DONE;
            end
            LADDR: begin
                ram_en   = 1'b1;
                ram_addr = cur_addr;
                state_d  = LWAIT;
            end
            LWAIT: begin
                ram_en   = 1'b1;
                ram_addr = cur_addr;
                if (wait_end) state_d = LCAP;
            end
            LCAP: begin
                ram_en   = 1'b1;
                ram_addr = cur_addr;
                state_d  = last_elem ? DONE : LWAIT;
            end
            DONE: begin
                xfer_done = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_cpu_regfile_xfer.sv
// tb_cpu_regfile_xfer: directed bench for cpu_regfile_xfer with a 1-cycle-latency RAM model.
// Latency: checks exact done timing and per-cycle RAM write addresses/data.
// Backpressure: not applicable; the bench waits on xfer_done with cycle budgets.
module tb_cpu_regfile_xfer;
    logic        clk = 1'b0;
    logic        res_n = 1'b0;
    logic [3:0]  rd_a_sel = '0, rd_b_sel = '0, wr_a_sel = '0, xfer_first = '0, xfer_last = '0;
    logic [7:0]  wr_a_data = '0, wr_f_data = '0;
    logic [7:0]  rd_a_data, rd_b_data, ram_in, ram_out;
    logic        wr_a_en = 1'b0, wr_f_en = 1'b0, xfer_start = 1'b0, xfer_dir = 1'b0, xfer_rpl = 1'b0;
    logic        xfer_busy, xfer_done, ram_en, ram_wr;
    logic [11:0] xfer_base = '0;
    logic [11:0] xfer_next_addr, ram_addr;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    cpu_regfile_xfer dut (
        .clk(clk), .res_n(res_n),
        .rd_a_sel(rd_a_sel), .rd_a_data(rd_a_data),
        .rd_b_sel(rd_b_sel), .rd_b_data(rd_b_data),
        .wr_a_en(wr_a_en), .wr_a_sel(wr_a_sel), .wr_a_data(wr_a_data),
        .wr_f_en(wr_f_en), .wr_f_data(wr_f_data),
        .xfer_start(xfer_start), .xfer_dir(xfer_dir), .xfer_rpl(xfer_rpl),
        .xfer_first(xfer_first), .xfer_last(xfer_last), .xfer_base(xfer_base),
        .xfer_busy(xfer_busy), .xfer_done(xfer_done), .xfer_next_addr(xfer_next_addr),
        .ram_en(ram_en), .ram_wr(ram_wr), .ram_addr(ram_addr), .ram_in(ram_in), .ram_out(ram_out)
    );

    // RAM model: synchronous write, registered read (data ready one cycle after the address)
    logic [7:0]  mem [4096];
    logic        tb_we = 1'b0;
    logic [11:0] tb_wa = '0;
    logic [7:0]  tb_wd = '0;
    always @(posedge clk) begin
        if (tb_we) mem[tb_wa] <= tb_wd;
        else if (ram_en && ram_wr) mem[ram_addr] <= ram_in;
        if (ram_en) ram_out <= mem[ram_addr];
    end

    // Cycle counter and bus monitor (write log, done pulses, RAM enable cycles)
    int          cyc = 0;
    int          log_n = 0, done_cnt = 0, en_cnt = 0;
    logic [11:0] log_addr [256];
    logic [7:0]  log_dat [256];
    int          log_cyc [256];
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (ram_en && ram_wr && log_n < 256) begin
            log_addr[log_n] = ram_addr;
            log_dat[log_n]  = ram_in;
            log_cyc[log_n]  = cyc;
            log_n = log_n + 1;
        end
        if (xfer_done) done_cnt = done_cnt + 1;
        if (ram_en) en_cnt = en_cnt + 1;
    end

    task automatic wr_reg(input logic [3:0] sel, input logic [7:0] d);
        @(negedge clk);
        wr_a_en = 1'b1; wr_a_sel = sel; wr_a_data = d;
        @(negedge clk);
        wr_a_en = 1'b0;
    endtask

    task automatic preload(input logic [11:0] a, input logic [7:0] d);
        @(negedge clk);
        tb_we = 1'b1; tb_wa = a; tb_wd = d;
        @(negedge clk);
        tb_we = 1'b0;
    endtask

    task automatic start_xfer(input logic dir, input logic rpl, input logic [3:0] f,
                              input logic [3:0] l, input logic [11:0] b, output int scyc);
        @(negedge clk);
        xfer_dir = dir; xfer_rpl = rpl; xfer_first = f; xfer_last = l; xfer_base = b;
        xfer_start = 1'b1;
        scyc = cyc;
        @(negedge clk);
        xfer_start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit got, output int dcyc);
        got = 1'b0;
        dcyc = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (xfer_done) begin
                got = 1'b1;
                dcyc = cyc;
                break;
            end
        end
    endtask

    task automatic test_reset();
        res_n = 1'b0;
        repeat (2) @(negedge clk);
        rd_a_sel = 4'd0; rd_b_sel = 4'd15; #1;
        checks++;
        if (rd_a_data !== 8'h00 || rd_b_data !== 8'h00) begin
            failures++; $display("FAIL reset_regs got=%0h/%0h exp=0/0", rd_a_data, rd_b_data);
        end
        checks++;
        if ({ram_en, ram_wr, xfer_busy, xfer_done} !== 4'b0000) begin
            failures++; $display("FAIL reset_ctrl got=%b exp=0000", {ram_en, ram_wr, xfer_busy, xfer_done});
        end
        checks++;
        if (ram_addr !== 12'h000 || ram_in !== 8'h00 || xfer_next_addr !== 12'h000) begin
            failures++;
            $display("FAIL reset_bus got=%0h/%0h/%0h exp=0/0/0", ram_addr, ram_in, xfer_next_addr);
        end
        @(negedge clk);
        res_n = 1'b1;
    endtask

    task automatic test_store_basic();
        int s, d, base, bad;
        bit got;
        logic [7:0] e;
        for (int i = 0; i < 4; i++) wr_reg(4'(i), 8'((i + 1) * 17));
        base = log_n;
        start_xfer(1'b0, 1'b0, 4'd0, 4'd3, 12'h300, s);
        wait_done(20, got, d);
        checks++;
        if (!got || d - s != 5) begin
            failures++; $display("FAIL store_done_time got=%0d exp=5", d - s);
        end
        checks++;
        if (log_n - base != 4) begin
            failures++; $display("FAIL store_count got=%0d exp=4", log_n - base);
        end
        bad = -1;
        for (int i = 0; i < 4; i++) begin
            e = 8'((i + 1) * 17);
            if (bad < 0 && (log_addr[base+i] !== 12'(12'h300 + i) || log_dat[base+i] !== e
                            || log_cyc[base+i] != s + 1 + i)) bad = i;
        end
        checks++;
        if (bad >= 0) begin
            failures++;
            $display("FAIL store_beats idx=%0d got=%0h:%0h@%0d exp=%0h:%0h@%0d", bad, log_addr[base+bad],
                     log_dat[base+bad], log_cyc[base+bad] - s, 12'(12'h300 + bad), 8'((bad + 1) * 17), bad + 1);
        end
        checks++;
        if (xfer_next_addr !== 12'h304 || xfer_busy !== 1'b0) begin
            failures++; $display("FAIL store_next_addr got=%0h busy=%b exp=304 busy=0", xfer_next_addr, xfer_busy);
        end
        @(negedge clk);
        checks++;
        if (xfer_done !== 1'b0) begin
            failures++; $display("FAIL done_pulse_width got=%b exp=0", xfer_done);
        end
    endtask

    task automatic test_load_desc();
        int s, d, base;
        bit got;
        preload(12'h200, 8'hAA);
        preload(12'h201, 8'hBB);
        preload(12'h202, 8'hCC);
        base = log_n;
        start_xfer(1'b1, 1'b0, 4'd5, 4'd3, 12'h200, s);
        checks++;
        if (xfer_busy !== 1'b1 || ram_wr !== 1'b0) begin
            failures++; $display("FAIL load_busy got=%b/%b exp=1/0", xfer_busy, ram_wr);
        end
        wait_done(30, got, d);
        checks++;
        if (!got || d - s != 8) begin
            failures++; $display("FAIL load_done_time got=%0d exp=8", d - s);
        end
        rd_a_sel = 4'd5; rd_b_sel = 4'd4; #1;
        checks++;
        if (rd_a_data !== 8'hAA || rd_b_data !== 8'hBB) begin
            failures++; $display("FAIL load_v5_v4 got=%0h/%0h exp=aa/bb", rd_a_data, rd_b_data);
        end
        rd_a_sel = 4'd3; #1;
        checks++;
        if (rd_a_data !== 8'hCC || xfer_next_addr !== 12'h203 || log_n != base) begin
            failures++;
            $display("FAIL load_v3_next got=%0h/%0h/%0d exp=cc/203/0", rd_a_data, xfer_next_addr, log_n - base);
        end
    endtask

    task automatic test_wrap();
        int s, d, base;
        bit got;
        base = log_n;
        start_xfer(1'b0, 1'b0, 4'd0, 4'd1, 12'hFFF, s);
        wait_done(20, got, d);
        checks++;
        if (!got || d - s != 3 || log_n - base != 2) begin
            failures++; $display("FAIL wrap_time got=%0d/%0d exp=3/2", d - s, log_n - base);
        end
        checks++;
        if (log_addr[base] !== 12'hFFF || log_dat[base] !== 8'h11 ||
            log_addr[base+1] !== 12'h000 || log_dat[base+1] !== 8'h22) begin
            failures++;
            $display("FAIL wrap_beats got=%0h:%0h,%0h:%0h exp=fff:11,0:22", log_addr[base], log_dat[base],
                     log_addr[base+1], log_dat[base+1]);
        end
        checks++;
        if (xfer_next_addr !== 12'h001) begin
            failures++; $display("FAIL wrap_next_addr got=%0h exp=1", xfer_next_addr);
        end
    endtask

    task automatic test_busy_rules();
        int s, d, base, dc0;
        bit got;
        @(negedge clk);
        rd_a_sel = 4'd15;
        wr_a_en = 1'b1; wr_a_sel = 4'd15; wr_a_data = 8'h12;
        wr_f_en = 1'b1; wr_f_data = 8'h34;
        #1;
        checks++;
        if (rd_a_data !== 8'h00) begin
            failures++; $display("FAIL read_no_bypass got=%0h exp=0", rd_a_data);
        end
        @(negedge clk);
        wr_a_en = 1'b0; wr_f_en = 1'b0; #1;
        checks++;
        if (rd_a_data !== 8'h34) begin
            failures++; $display("FAIL flag_wins got=%0h exp=34", rd_a_data);
        end
        base = log_n;
        dc0 = done_cnt;
        start_xfer(1'b0, 1'b0, 4'd0, 4'd15, 12'h400, s);
        // Write and restart while busy: both must be dropped
        wr_a_en = 1'b1; wr_a_sel = 4'd1; wr_a_data = 8'h99;
        wr_f_en = 1'b1; wr_f_data = 8'h55;
        xfer_start = 1'b1; xfer_dir = 1'b1; xfer_first = 4'd2; xfer_last = 4'd2; xfer_base = 12'h500;
        @(negedge clk);
        wr_a_en = 1'b0; wr_f_en = 1'b0; xfer_start = 1'b0;
        wait_done(40, got, d);
        checks++;
        if (!got || d - s != 17 || log_n - base != 16) begin
            failures++; $display("FAIL busy_store16 got=%0d/%0d exp=17/16", d - s, log_n - base);
        end
        checks++;
        if (log_dat[base+3] !== 8'hCC || log_addr[base+15] !== 12'h40F || log_dat[base+15] !== 8'h34) begin
            failures++;
            $display("FAIL busy_store_data got=%0h,%0h:%0h exp=cc,40f:34", log_dat[base+3],
                     log_addr[base+15], log_dat[base+15]);
        end
        checks++;
        if (xfer_next_addr !== 12'h410) begin
            failures++; $display("FAIL busy_next_addr got=%0h exp=410", xfer_next_addr);
        end
        repeat (5) @(negedge clk);
        rd_a_sel = 4'd1; rd_b_sel = 4'd15; #1;
        checks++;
        if (rd_a_data !== 8'h22 || rd_b_data !== 8'h34 || done_cnt - dc0 != 1) begin
            failures++;
            $display("FAIL busy_dropped got=%0h/%0h/%0d exp=22/34/1", rd_a_data, rd_b_data, done_cnt - dc0);
        end
    endtask

    task automatic test_reset_mid_load();
        int s, d, dc0, bad;
        bit got;
        for (int i = 0; i < 16; i++) preload(12'(12'h600 + i), 8'(i + 1));
        start_xfer(1'b1, 1'b0, 4'd0, 4'd15, 12'h600, s);
        repeat (10) @(negedge clk);
        dc0 = done_cnt;
        res_n = 1'b0; #1;
        checks++;
        if (ram_en !== 1'b0 || xfer_busy !== 1'b0 || xfer_next_addr !== 12'h000) begin
            failures++;
            $display("FAIL midreset_ctrl got=%b/%b/%0h exp=0/0/0", ram_en, xfer_busy, xfer_next_addr);
        end
        bad = 0;
        for (int i = 0; i < 16; i++) begin
            rd_a_sel = 4'(i); #1;
            if (rd_a_data !== 8'h00) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++; $display("FAIL midreset_regs got=%0d nonzero exp=0", bad);
        end
        @(negedge clk);
        res_n = 1'b1;
        repeat (40) @(negedge clk);
        checks++;
        if (done_cnt != dc0) begin
            failures++; $display("FAIL midreset_no_done got=%0d exp=0", done_cnt - dc0);
        end
        start_xfer(1'b1, 1'b0, 4'd0, 4'd15, 12'h600, s);
        wait_done(60, got, d);
        checks++;
        if (!got || d - s != 34) begin
            failures++; $display("FAIL reload_time got=%0d exp=34", d - s);
        end
        rd_a_sel = 4'd0; rd_b_sel = 4'd15; #1;
        checks++;
        if (rd_a_data !== 8'h01 || rd_b_data !== 8'h10 || xfer_next_addr !== 12'h610) begin
            failures++;
            $display("FAIL reload_data got=%0h/%0h/%0h exp=1/10/610", rd_a_data, rd_b_data, xfer_next_addr);
        end
    endtask

`ifdef CPU_REGFILE_RPL_EN
    task automatic test_rpl();
        int s, d, en0, bad;
        bit got;
        for (int i = 0; i < 8; i++) wr_reg(4'(i), 8'(i + 1));
        en0 = en_cnt;
        start_xfer(1'b0, 1'b1, 4'd0, 4'd7, 12'h700, s);
        wait_done(20, got, d);
        checks++;
        if (!got || d - s != 9) begin
            failures++; $display("FAIL rpl_store_time got=%0d exp=9", d - s);
        end
        for (int i = 0; i < 8; i++) wr_reg(4'(i), 8'h00);
        start_xfer(1'b1, 1'b1, 4'd0, 4'd7, 12'h700, s);
        wait_done(20, got, d);
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            rd_a_sel = 4'(i); #1;
            if (rd_a_data !== 8'(i + 1)) bad++;
        end
        checks++;
        if (!got || bad != 0 || en_cnt != en0 || xfer_next_addr !== 12'h700) begin
            failures++;
            $display("FAIL rpl_roundtrip got=bad%0d/en%0d/%0h exp=0/0/700", bad, en_cnt - en0, xfer_next_addr);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_store_basic();
        test_load_desc();
        test_wrap();
        test_busy_rules();
        test_reset_mid_load();
`ifdef CPU_REGFILE_RPL_EN
        test_rpl();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/cpu_regfile_xfer.md
Name: cpu_regfile_xfer

Overview:
- Parametrised successor to the CHIP-8 register file.
- Combines the V-register array with a block-transfer sequencer that moves an arbitrary register range to or from RAM, either ascending or descending.
- Covers Fx55/Fx65 and the XO-CHIP 5XY2/5XY3 range forms, so the CPU only issues a start pulse and waits for done.
- Sits between the CPU execute stage and the shared RAM port.

Parameters:
NREGS, 16, number of registers; the last register (NREGS-1) is the flag register
W, 8, register and RAM data width
AW, 12, RAM address width
RD_WAIT, 1, idle cycles between presenting a read address and sampling ram_out (must be ≥1)
NFLAGS, 8, depth of the RPL flag bank (used only with the optional feature)

Ports:
clk  in  1  system clock
res_n  in  1  asynchronous active-low reset
rd_a_sel  in  IW=$clog2(NREGS)  read port A select
rd_a_data  out  W  register[rd_a_sel], combinational
rd_b_sel  in  IW  read port B select
rd_b_data  out  W  register[rd_b_sel], combinational
wr_a_en  in  1  write enable, port A
wr_a_sel  in  IW  port A write select
wr_a_data  in  W  port A write data
wr_f_en  in  1  flag register write enable
wr_f_data  in  W  flag register write data
xfer_start  in  1  one-cycle start pulse
xfer_dir  in  1  0 = store (regs to RAM), 1 = load (RAM to regs)
xfer_rpl  in  1  target is the flag bank instead of RAM (optional feature)
xfer_first  in  IW  first register of the range
xfer_last  in  IW  last register of the range
xfer_base  in  AW  RAM address for xfer_first
xfer_busy  out  1  transfer in progress
xfer_done  out  1  one-cycle pulse at completion
xfer_next_addr  out  AW  base+count, valid from the xfer_done pulse until the next start
ram_en  out  1  RAM enable
ram_wr  out  1  RAM write strobe
ram_addr  out  AW  RAM address
ram_in  out  W  RAM write data
ram_out  in  W  RAM read data

Behaviour:
- Reset (async, res_n low):
  - all registers = 0
  - ram_en = ram_wr = 0; ram_addr = 0; ram_in = 0
  - xfer_busy = 0, xfer_done = 0, xfer_next_addr = 0
  - state = IDLE
  - Reset mid-transfer aborts immediately; no done pulse is issued.
- Register writes (at clk edge):
  - Port A and the flag write may occur in the same cycle.
  - If wr_a_sel == NREGS-1 and both are enabled, wr_f wins.
  - External writes are ignored while xfer_busy = 1.
- Read ports: pure combinational; they show the pre-edge value during the write cycle (no bypass).
- Range:
  - dir_step = +1 if first ≤ last, else -1.
  - count = |last-first| + 1.
  - RAM address always increments from base, mod 2^AW (wraps from 0xFFF to 0x000).
  - Register k of the sequence is first + k*dir_step.
- State machine (IDLE, STORE, LADDR, LWAIT, LCAP, DONE):
  - IDLE: xfer_start latches first, last, base, dir, and rpl, then sets busy.
    - Store goes to STORE.
    - Load goes to LADDR.
    - xfer_start while busy is ignored.
  - STORE: each cycle drives ram_en = 1, ram_wr = 1, ram_addr = cur_addr, ram_in = reg[cur].
    - After the last element, go to DONE.
    - Throughput: 1 byte per clock, so count cycles in total.
  - LADDR: drives ram_en = 1, ram_wr = 0, ram_addr = cur_addr, then goes to LWAIT.
  - LWAIT: holds for RD_WAIT cycles, then goes to LCAP.
  - LCAP: reg[cur] ← ram_out.
    - If last element, go to DONE.
    - Otherwise advance the address and register, re-present the address, and return to LWAIT.
    - Cost: RD_WAIT+2 cycles for the first byte, RD_WAIT+1 for each later byte.
  - DONE: ram_en = 0, ram_wr = 0; xfer_done = 1 for one cycle; busy drops in the same cycle; next_addr = base+count; return to IDLE.
- ram_en and ram_wr are 0 at all times in IDLE.
- first == last is a single-element transfer.
- A range that includes register NREGS-1 behaves like any other register; it has no special flag semantics during a transfer.

Optional Feature:
- Macro: CPU_REGFILE_RPL_EN.
- With the macro:
  - An NFLAGS x W flag bank exists, reset to 0.
  - xfer_rpl = 1 routes the transfer to the bank instead of RAM; bank index = element index k.
  - Each element takes 1 cycle in both directions; RAM signals stay idle.
  - Any register index ≥ NFLAGS in the range is skipped (no access, no stall).
  - next_addr = base, unchanged.
- Without the macro:
  - xfer_rpl is ignored; the transfer always targets RAM.
  - No flag storage is synthesised.

Test Plan:
1. Reset, write V0..V3 = 11,22,33,44, store first=0 last=3 base=0x300 → RAM 0x300..0x303 = 11,22,33,44 on 4 consecutive cycles, done pulse, next_addr = 0x304.
2. Descending load with RAM 0x200 = AA, 0x201 = BB, 0x202 = CC, first=5 last=3 base=0x200, RD_WAIT=1 → V5=AA, V4=BB, V3=CC; done on cycle 3+2+2+1 after start.
3. Address wrap: store first=0 last=1 base=0xFFF → writes at 0xFFF then 0x000; next_addr = 0x001.
4. Same-cycle wr_a_sel=15 data=0x12 and wr_f data=0x34 → VF=0x34; wr_a during busy → dropped; second xfer_start during busy → no effect.
5. Assert res_n low in the middle of a 16-register load → all regs 0, ram_en = 0, no done pulse; a new load after release completes normally.
6. (CPU_REGFILE_RPL_EN) store V0..V7 = 1..8 with rpl = 1, clear regs, load with rpl = 1 → V0..V7 = 1..8, ram_en stays 0 throughout.
